mem_port_arbiter: RTL and testbench

Shares one single-port synchronous memory between the core's instruction-fetch requester and its load/store requester. Each requester uses a req/gnt handshake. The arbiter sequences a fixed-latency read response back to the owning port. When both ports contend, it alternates priority so neither starves. It sits between the fetch/LSU logic and the unified memory macro in the multicycle and pipelined core variants.

---
 rtl/mem_port_arbiter_pkg.sv | 10 +
 rtl/mem_port_arbiter.sv | 93 +++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory port arbiter
package mem_arb_pkg;
    localparam int ADDR_W_D  = 32;
    localparam int DATA_W_D  = 32;
    localparam int MEM_LAT_D = 1;
    localparam int CNT_W_D   = 3;

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch and load/store ports
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int MEM_LAT = MEM_LAT_D,
    parameter int CNT_W   = CNT_W_D
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_ls_req,
    input  logic                i_ls_we,
    input  logic [ADDR_W-1:0]   i_ls_addr,
    input  logic [DATA_W-1:0]   i_ls_wdata,
    input  logic [DATA_W/8-1:0] i_ls_bmask,
    output logic                o_ls_gnt,
    output logic                o_ls_rvalid,
    output logic [DATA_W-1:0]   o_ls_rdata,
    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_bmask,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_busy
);
    state_t           r_state, w_state_nxt;
    owner_t           r_owner, w_owner_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_ls_turn, w_ls_turn_nxt;
    logic             w_resp, w_win, w_if_gnt, w_ls_gnt, w_st_gnt, w_rd_gnt;

    assign w_resp   = (r_state == WAIT) && (r_cnt == CNT_W'(1));
    assign w_win    = !i_reset && ((r_state == IDLE) || w_resp);
    // r_ls_turn is the last_ls flag: set by an IF grant so LS wins the next tie
    assign w_if_gnt = w_win && i_if_req && (!i_ls_req || !r_ls_turn);
    assign w_ls_gnt = w_win && i_ls_req && (!i_if_req || r_ls_turn);
    assign w_st_gnt = w_ls_gnt && i_ls_we;
    assign w_rd_gnt = w_if_gnt || (w_ls_gnt && !i_ls_we);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_owner   <= OWN_IF;
            r_cnt     <= '0;
            r_ls_turn <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ls_turn <= w_ls_turn_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_cnt_nxt     = r_cnt;
        w_ls_turn_nxt = r_ls_turn;
        if (r_state == WAIT) begin
            w_cnt_nxt   = r_cnt - CNT_W'(1);
            w_state_nxt = w_resp ? IDLE : WAIT;
        end
        if (w_rd_gnt) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_W'(MEM_LAT);
            w_owner_nxt = w_ls_gnt ? OWN_LS : OWN_IF;
        end
        if (w_if_gnt || w_ls_gnt)
            w_ls_turn_nxt = w_if_gnt;
    end

    always_comb begin
        o_if_gnt    = w_if_gnt;
        o_ls_gnt    = w_ls_gnt;
        o_mem_en    = w_if_gnt || w_ls_gnt;
        o_mem_we    = w_st_gnt;
        o_mem_addr  = w_if_gnt ? i_if_addr : (w_ls_gnt ? i_ls_addr : '0);
        o_mem_wdata = w_st_gnt ? i_ls_wdata : '0;
        o_mem_bmask = w_st_gnt ? i_ls_bmask : '0;
        o_if_rvalid = w_resp && (r_owner == OWN_IF);
        o_ls_rvalid = w_resp && (r_owner == OWN_LS);
        o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
        o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;
        o_busy      = (r_state == WAIT);
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a memory model and transaction-level reference
module tb_mem_port_arbiter;
    localparam int LAT = 2;

    typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] bm;} txn_t;
    typedef struct {bit ls; logic [31:0] data; int due;} exp_t;

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic        if_req = 0, ls_req = 0, ls_we = 0;
    logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0;
    logic [3:0]  ls_bmask = 0;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_bmask;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .CNT_W(3)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
        .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
        .i_ls_bmask(ls_bmask), .o_ls_gnt(ls_gnt), .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_bmask(mem_bmask), .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    function automatic logic [31:0] init_w(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [64];
    logic [31:0] pipe [LAT];
    assign mem_rdata = pipe[LAT-1];
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_w(i);
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_bmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:2]] : $urandom;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    int nchk = 0, npass = 0;
    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        nchk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        else npass++;
    endtask

    txn_t if_q[$], ls_q[$];
    bit   dense = 1;
    int   if_xfers = 0, ls_xfers = 0;

    initial begin
        int if_seen = 0, ls_seen = 0;
        txn_t t;
        forever begin
            @(posedge clk); #1;
            if (if_xfers != if_seen) begin if_seen = if_xfers; if_req = 0; end
            if (ls_xfers != ls_seen) begin ls_seen = ls_xfers; ls_req = 0; end
            if (!if_req && if_q.size() > 0 && (dense || $urandom_range(3) != 0)) begin
                t = if_q.pop_front();
                if_req = 1; if_addr = t.addr;
            end
            if (!ls_req && ls_q.size() > 0 && (dense || $urandom_range(3) != 0)) begin
                t = ls_q.pop_front();
                ls_req = 1; ls_we = t.we; ls_addr = t.addr; ls_wdata = t.wdata; ls_bmask = t.bm;
            end
        end
    end

    logic [31:0] ref_mem [64];
    exp_t        sb[$];
    logic [31:0] ls_log[$];
    int          free_at = 0, gcyc = -1, resp_at = -1, first_g = 0;
    bit          prio_if = 1, coin_seen = 0;

    initial begin
        exp_t e;
        bit eg_if, eg_ls, ev_if, ev_ls, eb;
        logic [31:0] ed;
        logic [69:0] ecmd;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_w(i);
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs",
                    {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_en, mem_we,
                     mem_addr, mem_wdata, mem_bmask, busy}, '0);
                sb.delete();
                free_at = 0; gcyc = -1; resp_at = -1; prio_if = 1; first_g = 0;
            end else begin
                eg_if = (cyc >= free_at) && if_req && (!ls_req || prio_if);
                eg_ls = (cyc >= free_at) && ls_req && (!if_req || !prio_if);
                chk("if_gnt", if_gnt, eg_if);
                chk("ls_gnt", ls_gnt, eg_ls);
                ecmd = eg_if ? {2'b10, if_addr, 36'h0} :
                       eg_ls ? (ls_we ? {2'b11, ls_addr, ls_wdata, ls_bmask} : {2'b10, ls_addr, 36'h0}) : '0;
                chk("mem_cmd", {mem_en, mem_we, mem_addr, mem_wdata, mem_bmask}, ecmd);
                eb = (cyc > gcyc) && (cyc <= resp_at);
                chk("busy", busy, eb);
                ev_if = 0; ev_ls = 0; ed = 0;
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    ev_ls = e.ls; ev_if = !e.ls; ed = e.data;
                end
                chk("if_resp", {if_rvalid, if_rdata}, {ev_if, ev_if ? ed : 32'h0});
                chk("ls_resp", {ls_rvalid, ls_rdata}, {ev_ls, ev_ls ? ed : 32'h0});
                if (ls_rvalid) ls_log.push_back(ls_rdata);
                if (ls_rvalid && if_gnt && busy) coin_seen = 1;
                if (first_g == 0 && (if_gnt || ls_gnt)) first_g = if_gnt ? 1 : 2;
                if (if_gnt && if_req) if_xfers++;
                if (ls_gnt && ls_req) ls_xfers++;
                if (eg_if || (eg_ls && !ls_we)) begin
                    e.ls = eg_ls;
                    e.data = ref_mem[eg_ls ? ls_addr[7:2] : if_addr[7:2]];
                    e.due = cyc + LAT;
                    sb.push_back(e);
                    free_at = cyc + LAT; gcyc = cyc; resp_at = cyc + LAT;
                end else if (eg_ls) begin
                    for (int b = 0; b < 4; b++)
                        if (ls_bmask[b]) ref_mem[ls_addr[7:2]][8*b +: 8] = ls_wdata[8*b +: 8];
                    free_at = cyc + 1;
                end
                if (eg_if || eg_ls) prio_if = eg_ls;
            end
        end
    end

    function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.bm = m;
        return t;
    endfunction

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while (!(if_q.size() == 0 && ls_q.size() == 0 && !if_req && !ls_req && sb.size() == 0) && n < budget) begin
            @(posedge clk); n++;
        end
        chk(nm, n < budget, 1'b1);
    endtask

    task automatic wait_xfer(input bit ls, input int tgt);
        int n = 0;
        while ((ls ? ls_xfers : if_xfers) < tgt && n < 100) begin
            @(posedge clk); n++;
        end
        chk("gnt_wait", n < 100, 1'b1);
    endtask

    initial begin
        logic [31:0] r;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 3; i++) if_q.push_back(mk(0, 32'(4 * i), 0, 0));
        repeat (3) @(posedge clk);
        #1 rst = 0;
        drain("fetch_only_drain", 200);

        for (int i = 0; i < 6; i++) begin
            if_q.push_back(mk(0, 32'h40 + 32'(4 * i), 0, 0));
            ls_q.push_back(mk(0, 32'h80 + 32'(4 * i), 0, 0));
        end
        drain("contended_drain", 200);

        ls_log.delete();
        ls_q.push_back(mk(1, 32'h10, 32'hDEADBEEF, 4'hF));
        ls_q.push_back(mk(0, 32'h10, 0, 0));
        ls_q.push_back(mk(1, 32'h10, 32'h0000AB00, 4'h2));
        ls_q.push_back(mk(0, 32'h10, 0, 0));
        drain("store_load_drain", 200);
        r = ls_log.size() > 0 ? ls_log[0] : 32'h0;
        chk("lw_after_sw", r, 32'hDEADBEEF);
        r = ls_log.size() > 1 ? ls_log[1] : 32'h0;
        chk("lw_after_sb", r, 32'hDEADABEF);

        coin_seen = 0;
        ls_q.push_back(mk(0, 32'h20, 0, 0));
        wait_xfer(1, ls_xfers + 1);
        if_q.push_back(mk(0, 32'h24, 0, 0));
        drain("overlap_drain", 200);
        chk("rvalid_gnt_same_cycle", coin_seen, 1'b1);

        if_q.push_back(mk(0, 32'h30, 0, 0));
        wait_xfer(0, if_xfers + 1);
        #2 rst = 1;
        #1 chk("busy_at_reset", busy, 1'b0);
        if_q.push_back(mk(0, 32'h34, 0, 0));
        ls_q.push_back(mk(0, 32'h38, 0, 0));
        repeat (2) @(posedge clk);
        #1 rst = 0;
        drain("post_reset_drain", 200);
        chk("post_reset_first_gnt", first_g, 1);

        dense = 0;
        for (int i = 0; i < 300; i++) begin
            r = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(1) == 0) if_q.push_back(mk(0, r, 0, 0));
            else ls_q.push_back(mk(1'($urandom_range(1)), r, $urandom, 4'($urandom_range(15))));
        end
        drain("random_drain", 5000);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
